// File: rtl/draw_scheduler.sv
// draw_scheduler
// Per-frame sequencer and pixel/ROM bus arbiter for the clear, map and tile drawing engines.
// On each frame_tick the enabled engines run one at a time in the order clear -> map -> tile.
// The running engine owns the vga_adapter pixel bus and the shared tile ROM address bus.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   frame_tick        one-cycle frame start pulse
//   stage_en[2:0]     engine enables: [0]=clear, [1]=map, [2]=tile
//   eng_start[2:0]    one-cycle start pulse per engine
//   eng_done[2:0]     engine done levels (rising edge ends a stage)
//   eng_plot/x/y/rgb  packed per-engine pixel requests, engine i at [i*W +: W]
//   eng_rom_addr      packed per-engine ROM addresses
//   vga_plot/x/y/rgb  registered pixel bus to vga_adapter
//   rom_addr          combinational ROM address of the current owner
//   owner             0..2 = engine owning the buses, 3 = none
//   busy, frame_done  frame in progress / one-cycle completion pulse
//   timeout_flag      sticky: an engine was aborted
//   overrun_cnt       saturating count of frame ticks dropped while busy
module draw_scheduler #(
   parameter int unsigned X_W            = 8,
   parameter int unsigned Y_W            = 7,
   parameter int unsigned RGB_W          = 24,
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frame_tick,
   input  logic [2:0]          stage_en,
   output logic [2:0]          eng_start,
   input  logic [2:0]          eng_done,
   input  logic [2:0]          eng_plot,
   input  logic [3*X_W-1:0]    eng_x,
   input  logic [3*Y_W-1:0]    eng_y,
   input  logic [3*RGB_W-1:0]  eng_rgb,
   input  logic [3*ADDR_W-1:0] eng_rom_addr,
   output logic                vga_plot,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [RGB_W-1:0]    vga_rgb,
   output logic [ADDR_W-1:0]   rom_addr,
   output logic [1:0]          owner,
   output logic                busy,
   output logic                frame_done,
   output logic                timeout_flag,
   output logic [7:0]          overrun_cnt
);

   typedef enum logic [1:0] {StIdle, StStart, StWait, StFinish} state_e;

   localparam logic [1:0]  OwnerNone = 2'd3;
   localparam logic [19:0] TmoLast   = 20'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [1:0]  stage_q, stage_d;
   logic [19:0] tmo_cnt_q, tmo_cnt_d;
   logic [2:0]  done_prev_q;
   logic        set_timeout;
   logic        done_edge;
   logic [2:0]  cand;
   logic [1:0]  next_stage;

   // Only a fresh rising edge ends a stage; a done level left over from a previous frame is ignored.
   assign done_edge = eng_done[stage_q] & ~done_prev_q[stage_q];

   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      tmo_cnt_d   = tmo_cnt_q;
      set_timeout = 1'b0;
      // Candidate stages: all from idle, otherwise only those above the current stage.
      if (state_q == StIdle) begin
         cand = stage_en;
      end else begin
         cand = stage_en & ~((3'b010 << stage_q) - 3'd1);
      end
      if (cand[0]) begin
         next_stage = 2'd0;
      end else if (cand[1]) begin
         next_stage = 2'd1;
      end else if (cand[2]) begin
         next_stage = 2'd2;
      end else begin
         next_stage = OwnerNone;
      end

      unique case (state_q)
         StIdle: begin
            if (frame_tick) begin
               if (next_stage == OwnerNone) begin
                  state_d = StFinish;
               end else begin
                  state_d = StStart;
                  stage_d = next_stage;
               end
            end
         end
         StStart: begin
            state_d   = StWait;
            tmo_cnt_d = '0;
         end
         StWait: begin
            if (done_edge || tmo_cnt_q == TmoLast) begin
               // A done edge in the abort cycle wins and does not flag a timeout.
               set_timeout = ~done_edge;
               if (next_stage == OwnerNone) begin
                  state_d = StFinish;
               end else begin
                  state_d = StStart;
                  stage_d = next_stage;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + 20'd1;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      busy       = (state_q != StIdle);
      frame_done = (state_q == StFinish);
      owner      = (state_q == StStart || state_q == StWait) ? stage_q : OwnerNone;
      eng_start  = (state_q == StStart) ? (3'b001 << stage_q) : 3'b000;
      rom_addr   = '0;
      if (owner != OwnerNone) begin
         rom_addr = eng_rom_addr[int'(owner)*ADDR_W +: ADDR_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         stage_q      <= 2'd0;
         tmo_cnt_q    <= '0;
         done_prev_q  <= '0;
         timeout_flag <= 1'b0;
         overrun_cnt  <= '0;
      end else begin
         state_q     <= state_d;
         stage_q     <= stage_d;
         tmo_cnt_q   <= tmo_cnt_d;
         done_prev_q <= eng_done;
         if (set_timeout) begin
            timeout_flag <= 1'b1;
         end
         if (frame_tick && state_q != StIdle && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end
      end
   end

   // Pixel bus registered from the current owner; the outgoing owner's last plot still lands one
   // cycle after ownership moves. Coordinates and colour hold while nobody owns the bus.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_plot <= 1'b0;
         vga_x    <= '0;
         vga_y    <= '0;
         vga_rgb  <= '0;
      end else if (owner != OwnerNone) begin
         vga_plot <= eng_plot[owner];
         vga_x    <= eng_x[int'(owner)*X_W +: X_W];
         vga_y    <= eng_y[int'(owner)*Y_W +: Y_W];
         vga_rgb  <= eng_rgb[int'(owner)*RGB_W +: RGB_W];
      end else begin
         vga_plot <= 1'b0;
      end
   end

endmodule
